// File: rtl/raster_setup_sched.sv
// Per-line / per-frame setup scheduler: shadow -> active -> working banks for edge and bary inits.
// Optional RASTER_SETUP_OVR_EN adds ovr_cnt, counting commits that overwrite a still-pending frame.
module raster_setup_sched #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [4:0]  cfg_addr,
  input  logic [21:0] cfg_data,
  input  logic        cfg_commit,
  output logic        frame_ack,
  output logic [19:0] e0_init_t1,
  output logic [19:0] e1_init_t1,
  output logic [19:0] e2_init_t1,
  output logic [19:0] e0_init_t2,
  output logic [19:0] e1_init_t2,
  output logic [19:0] e2_init_t2,
  output logic [21:0] bar_iy,
  output logic [21:0] bar_iz,
  output logic [21:0] bar2_iy,
  output logic [21:0] bar2_iz
`ifdef RASTER_SETUP_OVR_EN
  ,
  output logic [7:0]  ovr_cnt
`endif
);

  localparam int unsigned NumWords = 20;
  localparam int unsigned NumWork  = 10;
  localparam int unsigned NumEdge  = 6;

  // All ten steps must finish before the raster latch column.
  if (H_ACTIVE + NumWork + 1 > H_TOTAL - 1) begin : g_timing_check
    $error("hblank too short for the step sequence");
  end

  typedef enum logic [1:0] {StIdle, StCopy, StLoad, StStep} state_e;

  state_e      state_q;
  logic [3:0]  idx_q;
  logic        pending_q, pending_d;
  logic [21:0] shadow_q [NumWords];
  logic [21:0] active_q [NumWords];
  logic [21:0] work_q   [NumWork];

  logic        frame_trig, line_trig, copy_en, cfg_we;
  logic [21:0] cfg_wdata, sum, step_res;
  logic [4:0]  step_sel;

  always_comb begin
    frame_trig = (y == 10'(V_TOTAL - 1)) && (x == 10'(H_ACTIVE));
    line_trig  = (y < 10'(V_ACTIVE - 1)) && (x == 10'(H_ACTIVE));
    copy_en    = (state_q == StCopy) && pending_q;
    // A commit in the copy cycle belongs to the next frame, so it keeps pending set.
    pending_d  = cfg_commit | (pending_q & ~copy_en);
    cfg_ready  = (state_q != StCopy);
    frame_ack  = copy_en;
    cfg_we     = cfg_valid && cfg_ready && (cfg_addr < 5'(NumWords));
    cfg_wdata  = (cfg_addr < 5'd12) ? {{2{cfg_data[19]}}, cfg_data[19:0]} : cfg_data;
    // Working index k takes its step from word k+6 (edges) or k+10 (bary).
    step_sel   = (idx_q < 4'(NumEdge)) ? {1'b0, idx_q} + 5'd6 : {1'b0, idx_q} + 5'd10;
    sum        = work_q[idx_q] + active_q[step_sel];
    step_res   = (idx_q < 4'(NumEdge)) ? {{2{sum[19]}}, sum[19:0]} : sum;
  end

`ifdef RASTER_SETUP_OVR_EN
  logic [7:0] ovr_q;
  assign ovr_cnt = ovr_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumWords; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      for (int i = 0; i < NumWork; i++) work_q[i] <= '0;
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
`ifdef RASTER_SETUP_OVR_EN
      ovr_q     <= '0;
`endif
    end else begin
      pending_q <= pending_d;
      if (cfg_we) shadow_q[cfg_addr] <= cfg_wdata;
`ifdef RASTER_SETUP_OVR_EN
      if (cfg_commit && pending_q && !copy_en && (ovr_q != 8'hFF)) ovr_q <= ovr_q + 8'd1;
`endif
      unique case (state_q)
        StIdle: begin
          if (frame_trig) begin
            state_q <= StCopy;
          end else if (line_trig) begin
            state_q <= StStep;
            idx_q   <= '0;
          end
        end
        StCopy: begin
          if (pending_q) active_q <= shadow_q;
          state_q <= StLoad;
        end
        StLoad: begin
          for (int i = 0; i < NumEdge; i++) work_q[i] <= active_q[i];
          for (int i = NumEdge; i < NumWork; i++) work_q[i] <= active_q[i + 6];
          state_q <= StIdle;
        end
        StStep: begin
          work_q[idx_q] <= step_res;
          if (idx_q == 4'(NumWork - 1)) begin
            state_q <= StIdle;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign e0_init_t1 = work_q[0][19:0];
  assign e1_init_t1 = work_q[1][19:0];
  assign e2_init_t1 = work_q[2][19:0];
  assign e0_init_t2 = work_q[3][19:0];
  assign e1_init_t2 = work_q[4][19:0];
  assign e2_init_t2 = work_q[5][19:0];
  assign bar_iy     = work_q[6];
  assign bar_iz     = work_q[7];
  assign bar2_iy    = work_q[8];
  assign bar2_iz    = work_q[9];

endmodule
